// File: rtl/fsm_trigger_payload_if.sv
// Host-side bundle between a Mealy FSM's output decode and the trigger/payload unit.
// Carries the host state, inputs and golden outputs in, and the payload-adjusted outputs and status out.
// No flow control: every signal is valid on every cycle.
interface fsm_trigger_payload_if #(
    parameter int NX = 7,
    parameter int NY = 9,
    parameter int SW = 4,
    parameter int CW = 8
);
    logic [SW-1:0] state_in;
    logic [NX-1:0] x_in;
    logic [NY-1:0] y_in;
    logic [NY-1:0] y_out;
    logic          fired;
    logic [CW-1:0] trig_cnt;

    modport master (
        output state_in, x_in, y_in,
        input  y_out, fired, trig_cnt
    );

    modport slave (
        input  state_in, x_in, y_in,
        output y_out, fired, trig_cnt
    );
endinterface

// File: rtl/fsm_trigger_payload.sv
// Counts qualified visits to a host state and, past a threshold, corrupts masked outputs.
// Latency: y_out is combinational from the inputs; fired/trig_cnt update on the falling edge.
// No backpressure: the block observes and rewrites the host outputs every cycle.
module fsm_trigger_payload #(
    parameter int            NX         = 7,
    parameter int            NY         = 9,
    parameter int            SW         = 4,
    parameter int            CW         = 8,
    parameter logic [SW-1:0] TRIG_STATE = SW'(8),
    parameter logic [NX-1:0] XMASK      = 7'b0000100,
    parameter logic [NX-1:0] XVAL       = 7'b0000100,
    parameter int            THRESH     = 5,
    parameter int            WIN        = 0,
    parameter int            SCOPE      = 0,
    parameter int            MODE       = 0,
    parameter logic [NY-1:0] PMASK      = 9'b000001011
) (
    input  logic clk,
    input  logic rst,
    fsm_trigger_payload_if.slave bus
);
    localparam int            WW       = (WIN > 1) ? $clog2(WIN + 1) : 1;
    localparam logic [CW-1:0] TH_LAST  = CW'(THRESH - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'((WIN > 0) ? WIN - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic [NY-1:0] frz;
    logic          fired_q;

    logic          ev;
    logic          at_last;
    logic          strike;
    logic          active;
    logic [NY-1:0] frz_src;
    logic [NY-1:0] y_pay;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wcnt    <= '0;
            frz     <= '0;
            fired_q <= 1'b0;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    if (ev) begin
                        // An event always beats a coincident window expiry.
                        cnt  <= cnt + 1'b1;
                        wcnt <= '0;
                        if (at_last) begin
                            state   <= FIRED;
                            fired_q <= 1'b1;
                            frz     <= bus.y_in;
                        end else begin
                            state <= COUNT;
                        end
                    end else if (state == COUNT && WIN > 0) begin
                        if (wcnt == WIN_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                FIRED: begin
                    fired_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    wcnt    <= '0;
                    fired_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ev      = (bus.state_in == TRIG_STATE) && ((bus.x_in & XMASK) == XVAL);
        at_last = (cnt == TH_LAST);
        // The firing event itself is already corrupted, before fired registers.
        strike  = fired_q || (ev && at_last);
        active  = !rst && ((SCOPE != 0) ? strike : (strike && ev));
        frz_src = fired_q ? frz : bus.y_in;
        if (MODE == 0) begin
            y_pay = bus.y_in & ~PMASK;
        end else if (MODE == 1) begin
            y_pay = bus.y_in ^ PMASK;
        end else begin
            y_pay = (bus.y_in & ~PMASK) | (frz_src & PMASK);
        end
        bus.y_out = active ? y_pay : bus.y_in;
    end

    assign bus.fired    = fired_q;
    assign bus.trig_cnt = cnt;
endmodule

// File: tb/tb_fsm_trigger_payload.sv
// Bench for fsm_trigger_payload: six configurations share one stimulus stream,
// checked first against hand-derived vectors, then against a behavioural model under random stimulus.
module tb_fsm_trigger_payload;
    localparam int NI = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] st  = '0;
    logic [6:0] x   = '0;
    logic [8:0] y   = '0;

    always #5 clk = ~clk;

    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if0 ();
    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if1 ();
    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if2 ();
    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if3 ();
    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if4 ();
    fsm_trigger_payload_if #(.NX(7), .NY(9), .SW(4), .CW(8)) if5 ();

    assign if0.state_in = st; assign if0.x_in = x; assign if0.y_in = y;
    assign if1.state_in = st; assign if1.x_in = x; assign if1.y_in = y;
    assign if2.state_in = st; assign if2.x_in = x; assign if2.y_in = y;
    assign if3.state_in = st; assign if3.x_in = x; assign if3.y_in = y;
    assign if4.state_in = st; assign if4.x_in = x; assign if4.y_in = y;
    assign if5.state_in = st; assign if5.x_in = x; assign if5.y_in = y;

    // A: defaults
    fsm_trigger_payload u0 (.clk(clk), .rst(rst), .bus(if0));
    // B: persistent payload scope
    fsm_trigger_payload #(.SCOPE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    // C: invert all outputs, threshold 2
    fsm_trigger_payload #(.MODE(1), .PMASK(9'h1FF), .THRESH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    // D: freeze low nibble, fire on first event
    fsm_trigger_payload #(.MODE(2), .PMASK(9'h00F), .THRESH(1), .SCOPE(1)) u3 (.clk(clk), .rst(rst), .bus(if3));
    // E: inactivity window 3
    fsm_trigger_payload #(.WIN(3)) u4 (.clk(clk), .rst(rst), .bus(if4));
    // F: different trigger, short window, freeze in event cycles only
    fsm_trigger_payload #(.TRIG_STATE(4'd3), .XMASK(7'h05), .XVAL(7'h01), .THRESH(3), .WIN(2),
                          .SCOPE(0), .MODE(2), .PMASK(9'h0F0)) u5 (.clk(clk), .rst(rst), .bus(if5));

    logic [8:0] yo [NI];
    logic       fo [NI];
    logic [7:0] co [NI];
    assign yo[0] = if0.y_out; assign fo[0] = if0.fired; assign co[0] = if0.trig_cnt;
    assign yo[1] = if1.y_out; assign fo[1] = if1.fired; assign co[1] = if1.trig_cnt;
    assign yo[2] = if2.y_out; assign fo[2] = if2.fired; assign co[2] = if2.trig_cnt;
    assign yo[3] = if3.y_out; assign fo[3] = if3.fired; assign co[3] = if3.trig_cnt;
    assign yo[4] = if4.y_out; assign fo[4] = if4.fired; assign co[4] = if4.trig_cnt;
    assign yo[5] = if5.y_out; assign fo[5] = if5.fired; assign co[5] = if5.trig_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", nm, inst, $time, got, exp);
        end
    endtask

    // Reference model: an event tally, an idle-run tally and a latched snapshot per instance.
    typedef struct {
        int ts; int xm; int xv; int th; int win; int sc; int mode; int pm;
    } cfg_t;
    cfg_t cfg [NI];
    int   m_cnt [NI];
    int   m_idle [NI];
    bit   m_fired [NI];
    int   m_frz [NI];

    function automatic bit is_ev(int i, int s, int xv_);
        return (s == cfg[i].ts) && ((xv_ & cfg[i].xm) == cfg[i].xv);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_idle[i] = 0; m_fired[i] = 1'b0; m_frz[i] = 0;
        end
    endfunction

    function automatic int model_y(int i, int s, int xv_, int yv);
        bit ev     = is_ev(i, s, xv_);
        bit strike = m_fired[i] || (ev && (m_cnt[i] + 1 == cfg[i].th));
        bit act    = (cfg[i].sc != 0) ? strike : (strike && ev);
        int pm     = cfg[i].pm;
        int keep   = yv & ~pm & 'h1FF;
        int held   = m_fired[i] ? m_frz[i] : yv;
        if (!act) return yv;
        if (cfg[i].mode == 0) return keep;
        if (cfg[i].mode == 1) return (yv ^ pm) & 'h1FF;
        return keep | (held & pm);
    endfunction

    function automatic void model_step(int i, int s, int xv_, int yv);
        if (m_fired[i]) return;
        if (is_ev(i, s, xv_)) begin
            m_cnt[i]++;
            m_idle[i] = 0;
            if (m_cnt[i] == cfg[i].th) begin
                m_fired[i] = 1'b1;
                m_frz[i]   = yv;
            end
        end else if (m_cnt[i] > 0 && cfg[i].win > 0) begin
            m_idle[i]++;
            if (m_idle[i] == cfg[i].win) begin
                m_cnt[i]  = 0;
                m_idle[i] = 0;
            end
        end
    endfunction

    typedef struct {
        logic       r;
        logic [3:0] s;
        logic [6:0] xv;
        logic [8:0] yv;
        int         inst;
        logic [8:0] ey;
        logic       ef;
        logic [7:0] ec;
    } vec_t;
    vec_t tbl [$];

    initial begin
        cfg[0] = '{8, 'h04, 'h04, 5, 0, 0, 0, 'h00B};
        cfg[1] = '{8, 'h04, 'h04, 5, 0, 1, 0, 'h00B};
        cfg[2] = '{8, 'h04, 'h04, 2, 0, 0, 1, 'h1FF};
        cfg[3] = '{8, 'h04, 'h04, 1, 0, 1, 2, 'h00F};
        cfg[4] = '{8, 'h04, 'h04, 5, 3, 0, 0, 'h00B};
        cfg[5] = '{3, 'h05, 'h01, 3, 2, 0, 2, 'h0F0};

        // r, state, x, y, instance, expected y_out, fired, trig_cnt (sampled before the cycle's edge)
        tbl.push_back('{1'b1, 4'd0, 7'h00, 9'h01B, 0, 9'h01B, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h01B, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h01B, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h01B, 1'b0, 8'd3});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h010, 1'b0, 8'd4});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 0, 9'h010, 1'b1, 8'd5});
        tbl.push_back('{1'b0, 4'd0, 7'h04, 9'h01B, 0, 9'h01B, 1'b1, 8'd5});
        tbl.push_back('{1'b0, 4'd0, 7'h04, 9'h01B, 1, 9'h010, 1'b1, 8'd5});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h010, 1'b1, 8'd5});
        tbl.push_back('{1'b1, 4'd0, 7'h00, 9'h0A5, 0, 9'h0A5, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h0A5, 2, 9'h0A5, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h0A5, 2, 9'h15A, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h0A5, 2, 9'h15A, 1'b1, 8'd2});
        tbl.push_back('{1'b1, 4'd0, 7'h00, 9'h003, 3, 9'h003, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h003, 3, 9'h003, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h1FC, 3, 9'h1F3, 1'b1, 8'd1});
        tbl.push_back('{1'b1, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h01B, 1'b0, 8'd3});
        tbl.push_back('{1'b0, 4'd8, 7'h04, 9'h01B, 4, 9'h010, 1'b0, 8'd4});
        tbl.push_back('{1'b0, 4'd0, 7'h00, 9'h01B, 4, 9'h01B, 1'b1, 8'd5});

        foreach (tbl[k]) begin
            @(posedge clk);
            rst = tbl[k].r; st = tbl[k].s; x = tbl[k].xv; y = tbl[k].yv;
            #2;
            check("vec_y_out", tbl[k].inst, int'(yo[tbl[k].inst]), int'(tbl[k].ey));
            check("vec_fired", tbl[k].inst, int'(fo[tbl[k].inst]), int'(tbl[k].ef));
            check("vec_trig_cnt", tbl[k].inst, int'(co[tbl[k].inst]), int'(tbl[k].ec));
        end

        for (int c = 0; c < 3000; c++) begin
            bit do_rst;
            int sel;
            @(posedge clk);
            do_rst = (c == 0) || ($urandom_range(0, 399) == 0);
            sel = $urandom_range(0, 3);
            x   = 7'($urandom);
            y   = 9'($urandom);
            case (sel)
                0: begin st = 4'd8; x = x | 7'h04; end
                1: begin st = 4'd3; x = (x & ~7'h05) | 7'h01; end
                2: st = 4'd3;
                default: st = 4'($urandom);
            endcase
            rst = do_rst;
            #2;
            if (do_rst) model_reset();
            for (int i = 0; i < NI; i++) begin
                int ey;
                ey = do_rst ? int'(y) : model_y(i, int'(st), int'(x), int'(y));
                check("rnd_y_out", i, int'(yo[i]), ey);
                check("rnd_fired", i, int'(fo[i]), int'(m_fired[i]));
                check("rnd_trig_cnt", i, int'(co[i]), m_cnt[i]);
            end
            if (!do_rst) begin
                for (int i = 0; i < NI; i++) model_step(i, int'(st), int'(x), int'(y));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsm_trigger_payload.md
# fsm_trigger_payload

Parametrised count-triggered payload unit for the Trojan-inserted FSM benchmark set. It sits between a host Mealy FSM's combinational output decode and the module outputs. It counts qualified visits to a chosen host state and, once a threshold is reached, corrupts a masked subset of outputs in one of three modes. It replaces per-benchmark hand-coded trigger counters with one block that adds an inactivity window, selectable payload scope and selectable payload mode.

## Interface
Parameters:
- NX, 7: host FSM input width
- NY, 9: host FSM output width
- SW, 4: host state-code width
- CW, 8: event counter width
- TRIG_STATE, 8: host state code that qualifies an event
- XMASK, 7'b0000100: input bits examined for event qualification
- XVAL, 7'b0000100: required value of masked input bits
- THRESH, 5: event count that fires the payload; legal range 1..2^CW-1
- WIN, 0: inactivity window in cycles; 0 disables the window
- SCOPE, 0: 0 = payload only in event cycles; 1 = payload in every cycle once fired
- MODE, 0: 0 = force-zero; 1 = invert; 2 = freeze
- PMASK, 9'b000001011: output bits affected by the payload

Ports:
- clk  in  1  clock; all registers update on the falling edge
- rst  in  1  reset, asynchronous, active-high
- state_in  in  SW  host FSM present-state code
- x_in  in  NX  host FSM inputs
- y_in  in  NY  host FSM golden (uncorrupted) outputs, combinational
- y_out  out  NY  outputs after payload
- fired  out  1  payload latched
- trig_cnt  out  CW  current event count

## Operation
- The event condition is `ev = (state_in == TRIG_STATE) && ((x_in & XMASK) == XVAL)`. It is combinational.
- The state machine has three states:
  - IDLE: cnt = 0.
  - COUNT: 0 < cnt < THRESH.
  - FIRED: cnt = THRESH. FIRED is sticky until rst.
- When ev = 1 and the block is not fired, cnt increments at the falling edge.
  - If cnt+1 == THRESH, the block enters FIRED and fired goes to 1.
  - THRESH = 1 goes from IDLE directly to FIRED.
- In FIRED, cnt saturates at THRESH and does not increment further.
- Strike: strike is combinational. It is true when either of the following holds:
  - fired = 1;
  - ev = 1 and cnt == THRESH-1. This is the firing event itself, so it is already corrupted.
- Payload active condition:
  - SCOPE = 0: active = strike && ev.
  - SCOPE = 1: active = strike.
- Payload modes, applied only when active:
  - MODE 0: y_out = y_in & ~PMASK.
  - MODE 1: y_out = y_in ^ PMASK.
  - MODE 2: y_out = (y_in & ~PMASK) | (frz & PMASK).
- frz register (MODE 2 only): captures y_in at the falling edge that enters FIRED, i.e. the golden value of the firing cycle. It then holds until rst.
  - In the firing cycle itself, the combinational frz source is y_in, so that cycle's y_out equals y_in.
- When not active, y_out = y_in.
- Window (WIN > 0):
  - wcnt counts cycles in COUNT with ev = 0.
  - wcnt clears on every ev.
  - When wcnt would reach WIN, cnt and wcnt clear to 0 and the block returns to IDLE at that edge.
  - The window is inactive in IDLE and FIRED.
  - If ev and window expiry coincide, ev wins: increment, wcnt cleared.
- Illegal state encodings (unreachable): recover to IDLE with cnt = 0.

## Timing
- Reset values: cnt = 0, wcnt = 0, frz = 0, fired = 0, trig_cnt = 0, state IDLE.
- y_out = y_in whenever rst is asserted.
- Latency from y_in, state_in and x_in to y_out is zero cycles (pure combinational path). No register is added on the output path.
- fired and trig_cnt are registered; they update at the falling edge following the qualifying cycle.
- rst asserted mid-count or after firing clears everything immediately, without waiting for a clock edge.

## Test plan
- THRESH=5, SCOPE=0, MODE=0, PMASK=0x00B, y_in=0x01B, ev held 1 for 6 cycles:
  - events 1-4: y_out = 0x01B;
  - event 5: y_out = 0x010 and fired = 1 after that edge;
  - event 6: y_out = 0x010, trig_cnt = 5.
- Same configuration, state_in ≠ TRIG_STATE after firing: y_out = y_in (0x01B). With SCOPE=1 and the same stimulus: y_out = 0x010.
- MODE=1, PMASK=0x1FF, THRESH=2, y_in=0x0A5, two events: second event y_out = 0x15A.
- MODE=2, PMASK=0x00F, THRESH=1, SCOPE=1:
  - firing cycle y_in=0x003 → y_out = 0x003, frz = 0x3;
  - next cycle y_in=0x1FC → y_out = 0x1F3.
- WIN=3, THRESH=5: 2 events then 3 idle cycles → trig_cnt returns to 0; 2 events, 2 idle cycles, 3 events → fired = 1.
- After fired = 1, pulse rst between clock edges → fired = 0, trig_cnt = 0, y_out = y_in immediately.
